snake_dir_ctrl: RTL
===================

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 SHALL have parameter INIT_DIR, default 2'b11, meaning the direction loaded on game start (00 up, 01 down, 10 left, 11 right).
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the number of buffered pending turns; only the value 2 is supported.
REQ-003 SHALL have port Clk, input, 1, the single system clock (100 MHz).
REQ-004 SHALL have port Rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have ports key_enC, key_enU, key_enD, key_enL, key_enR, input, 1 each, the debounced one-cycle key pulses from the button filter stage.
REQ-006 SHALL have port move_tick, input, 1, a one-cycle pulse from the game timer marking one snake step.
REQ-007 SHALL have port game_over, input, 1, a level from the collision logic.
REQ-008 SHALL have port dir, output, 2, the current movement direction.
REQ-009 SHALL have port step, output, 1, a one-cycle pulse meaning "advance snake one cell using dir".
REQ-010 SHALL have ports running, paused and over, output, 1 each, the one-hot state flags (all low in IDLE).
REQ-011 SHALL have port start_pulse, output, 1, a one-cycle pulse on the IDLE->RUN transition.
REQ-012 SHALL have port q_count, output, 2, the pending-turn occupancy (0..2).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE and OVER; all outputs SHALL be registered.
REQ-014 In IDLE, a key_enC pulse SHALL cause the following: go to RUN, load dir=INIT_DIR, flush the queue, and pulse start_pulse for 1 cycle.
REQ-015 In RUN, key_enC SHALL go to PAUSE; in PAUSE, key_enC SHALL go to RUN; in OVER, key_enC SHALL go to IDLE and flush the queue.
REQ-016 In RUN or PAUSE, game_over=1 SHALL go to OVER and flush the queue; game_over SHALL have priority over a key_enC pulse in the same cycle.
REQ-017 Direction keys SHALL be accepted only in RUN and ignored in all other states.
REQ-018 When several direction pulses arrive in one cycle, only one SHALL be taken, with priority U > D > L > R.
REQ-019 The reference direction for key validity SHALL be the queue tail if the queue is non-empty, else dir.
REQ-020 A candidate key SHALL be rejected if it equals the reference direction, or is its reverse (same bit1, different bit0).
REQ-021 A valid candidate SHALL be enqueued if q_count<2; when full, it SHALL be dropped silently.
REQ-022 On move_tick in RUN, on the next edge: step=1; if the queue is non-empty, dir takes the head and the head is popped; otherwise dir is unchanged.
REQ-023 move_tick in IDLE, PAUSE or OVER SHALL be ignored: no step, no pop.
REQ-024 With a simultaneous move_tick and valid key, the pop and push SHALL occur in the same cycle.
   - Validity uses the pre-pop reference (REQ-019).
   - The pushed key is not applied on this tick.
   - q_count nets the pop and push.
REQ-025 Latency SHALL be one cycle in each case:
   - key pulse to q_count update;
   - move_tick to step/dir update;
   - key_enC to state flags.

Reset
REQ-026 On Rst=1 at a clock edge, the block SHALL enter IDLE and set: dir=INIT_DIR, q_count=0, step=0, start_pulse=0, running=paused=over=0.
REQ-027 Reset asserted mid-game SHALL discard queued turns and pending pulses; the first valid edge after reset release SHALL see the IDLE state.

Structure
REQ-028 The direction encodings, state encodings, and a reverse-check function SHALL live in shared package snake_pkg, used also by the movement and collision blocks.
REQ-029 The 2-entry pending-turn buffer SHALL be a sub-module dir_fifo2, with:
   - push/pop/flush inputs;
   - head/tail/count outputs;
   - simultaneous push and pop supported when count>=1;
   - push-only when count=0.

Verification
REQ-030 Reset, then key_enC -> start_pulse=1 for 1 cycle, running=1, dir=11.
REQ-031 In RUN with dir=11, pulse key_enL then move_tick -> reverse key rejected, q_count stays 0, step=1, dir stays 11.
REQ-032 In RUN with dir=11, pulse U, then D, then L, then move_tick x3:
   - U is accepted;
   - D is rejected as the reverse of tail U;
   - L is accepted, q_count=2;
   - after the ticks, dir sequence is 00, 10, 10, each with step=1.
REQ-033 In RUN with a full queue (U, L), pulse D -> dropped, q_count stays 2.
REQ-034 In RUN, key_enC -> paused=1; a move_tick while paused gives step=0; key_enC again -> running=1.
REQ-035 In RUN, assert game_over and key_enC in the same cycle -> over=1, q_count=0; a later key_enC -> IDLE with all flags 0; Rst mid-RUN -> IDLE, dir=11.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake game types: direction and state encodings,
// plus the reverse-direction check used by the controller.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Opposite directions share the axis bit and differ in sense.
  function automatic logic is_reverse(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/dir_fifo2.sv
// Two-entry pending-turn buffer with flush and
// same-cycle push/pop.
module dir_fifo2
  import snake_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic [1:0] count
);

  logic [1:0] e0;
  logic [1:0] e1;
  logic [1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst || flush) begin
      cnt <= '0;
      e0  <= '0;
      e1  <= '0;
    end else if (push && pop && cnt != 2'd0) begin
      if (cnt == 2'd2) begin
        e0 <= e1;
        e1 <= din;
      end else begin
        e0 <= din;
      end
    end else if (pop && cnt != 2'd0) begin
      e0  <= e1;
      cnt <= cnt - 2'd1;
    end else if (push && cnt != 2'd2) begin
      if (cnt == 2'd0) e0 <= din;
      else             e1 <= din;
      cnt <= cnt + 2'd1;
    end
  end

  assign head  = e0;
  assign tail  = (cnt == 2'd2) ? e1 : e0;
  assign count = cnt;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake game run/pause/over FSM with a buffered,
// validated direction-turn queue.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter logic [1:0] INIT_DIR = 2'b11,
  parameter int         QDEPTH   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       key_enC,
  input  logic       key_enU,
  input  logic       key_enD,
  input  logic       key_enL,
  input  logic       key_enR,
  input  logic       move_tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       step,
  output logic       running,
  output logic       paused,
  output logic       over,
  output logic       start_pulse,
  output logic [1:0] q_count
);

  localparam logic [1:0] FULL = 2'(QDEPTH);

  state_t     state_q, state_d;
  logic [1:0] dir_d;
  logic       step_d;
  logic       start_d;
  logic       flush;
  logic       push;
  logic       pop;
  logic       has_key;
  logic       key_ok;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic [1:0] head;
  logic [1:0] tail;

  dir_fifo2 u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (cand),
    .head  (head),
    .tail  (tail),
    .count (q_count)
  );

  always_comb begin
    has_key = 1'b1;
    cand    = DIR_UP;
    priority case (1'b1)
      key_enU: cand = DIR_UP;
      key_enD: cand = DIR_DOWN;
      key_enL: cand = DIR_LEFT;
      key_enR: cand = DIR_RIGHT;
      default: has_key = 1'b0;
    endcase
  end

  // Validate against the newest pending turn, not the live dir.
  assign ref_dir = (q_count != 2'd0) ? tail : dir;
  assign key_ok  = has_key && (cand != ref_dir)
                && !is_reverse(cand, ref_dir);

  always_comb begin
    state_d = state_q;
    dir_d   = dir;
    step_d  = 1'b0;
    start_d = 1'b0;
    flush   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (key_enC) begin
          state_d = ST_RUN;
          dir_d   = INIT_DIR;
          flush   = 1'b1;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_OVER;
          flush   = 1'b1;
        end else begin
          if (move_tick) begin
            step_d = 1'b1;
            if (q_count != 2'd0) begin
              dir_d = head;
              pop   = 1'b1;
            end
          end
          if (key_ok && q_count != FULL) push = 1'b1;
          if (key_enC) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_OVER;
          flush   = 1'b1;
        end else if (key_enC) begin
          state_d = ST_RUN;
        end
      end
      ST_OVER: begin
        if (key_enC) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      dir         <= INIT_DIR;
      step        <= 1'b0;
      start_pulse <= 1'b0;
      running     <= 1'b0;
      paused      <= 1'b0;
      over        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir         <= dir_d;
      step        <= step_d;
      start_pulse <= start_d;
      running     <= (state_d == ST_RUN);
      paused      <= (state_d == ST_PAUSE);
      over        <= (state_d == ST_OVER);
    end
  end

endmodule
